sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 14 +
 rtl/sdram_arb_id_fifo.sv | 46 ++++
 rtl/sdram_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and widths for the two-port SDRAM arbiter
package sdram_arb_pkg;

  localparam int LEN_W = 8;
  localparam int WR_W  = 4;

  typedef logic port_id_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// rtl/sdram_arb_id_fifo.sv - in-order queue of port IDs awaiting a core ack
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_t push_id_i,
  input  logic     pop_i,
  output port_id_t head_id_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  port_id_t           mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               do_push, do_pop;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  // A push at full is legal when the head leaves in the same cycle.
  assign do_push   = push_i & (~full_o | pop_i);
  assign do_pop    = pop_i & ~empty_o;
  assign head_id_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port arbiter in front of sdram_core_32bit with in-order ack routing
// Define SDRAM_ARB_RR_EN for round-robin priority; otherwise port 0 has fixed priority.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WR_W-1:0]   p0_wr_i,
  input  logic              p0_rd_i,
  input  logic [LEN_W-1:0]  p0_len_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_write_data_i,
  output logic              p0_accept_o,
  output logic              p0_ack_o,
  output logic              p0_error_o,
  output logic [DATA_W-1:0] p0_read_data_o,
  input  logic [WR_W-1:0]   p1_wr_i,
  input  logic              p1_rd_i,
  input  logic [LEN_W-1:0]  p1_len_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_write_data_i,
  output logic              p1_accept_o,
  output logic              p1_ack_o,
  output logic              p1_error_o,
  output logic [DATA_W-1:0] p1_read_data_o,
  output logic [WR_W-1:0]   outport_wr_o,
  output logic              outport_rd_o,
  output logic [LEN_W-1:0]  outport_len_o,
  output logic [ADDR_W-1:0] outport_addr_o,
  output logic [DATA_W-1:0] outport_write_data_o,
  input  logic              outport_accept_i,
  input  logic              outport_ack_i,
  input  logic              outport_error_i,
  input  logic [DATA_W-1:0] outport_read_data_i
);

  arb_state_t state_q, state_d;
  port_id_t   grant_q, grant_d, grant, pick, head_id;
  logic       grant_vld, req0, req1;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, q_full;
  logic       proto_err_q, proto_err_d;

  assign req0 = (p0_wr_i != '0) | p0_rd_i;
  assign req1 = (p1_wr_i != '0) | p1_rd_i;

`ifdef SDRAM_ARB_RR_EN
  port_id_t prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (fifo_push) prio_d = ~grant;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  assign pick = (req0 & req1) ? prio_q : req1;
`else
  assign pick = ~req0 & req1;
`endif

  // The head may leave this cycle, which frees a slot for a same-cycle accept.
  assign fifo_pop = outport_ack_i & ~fifo_empty & ~rst_i;
  assign q_full   = fifo_full & ~fifo_pop;

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    grant                = grant_q;
    grant_vld            = 1'b0;
    fifo_push            = 1'b0;
    p0_accept_o          = 1'b0;
    p1_accept_o          = 1'b0;
    outport_wr_o         = '0;
    outport_rd_o         = 1'b0;
    outport_len_o        = '0;
    outport_addr_o       = '0;
    outport_write_data_o = '0;
    if (state_q == ST_IDLE) begin
      grant     = pick;
      grant_vld = req0 | req1;
    end else begin
      grant_vld = grant_q ? req1 : req0;
    end
    if (grant_vld && !q_full && !rst_i) begin
      outport_wr_o         = grant ? p1_wr_i         : p0_wr_i;
      outport_rd_o         = grant ? p1_rd_i         : p0_rd_i;
      outport_len_o        = grant ? p1_len_i        : p0_len_i;
      outport_addr_o       = grant ? p1_addr_i       : p0_addr_i;
      outport_write_data_o = grant ? p1_write_data_i : p0_write_data_i;
      p0_accept_o          = outport_accept_i & ~grant;
      p1_accept_o          = outport_accept_i & grant;
      fifo_push            = outport_accept_i;
      grant_d              = grant;
      state_d              = outport_accept_i ? ST_IDLE : ST_LOCKED;
    end
  end

  assign proto_err_d = proto_err_q | (outport_ack_i & fifo_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      proto_err_q <= proto_err_d;
    end
  end

  sdram_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifo_push),
    .push_id_i (grant),
    .pop_i     (fifo_pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign p0_ack_o       = fifo_pop & ~head_id;
  assign p1_ack_o       = fifo_pop & head_id;
  assign p0_error_o     = p0_ack_o & outport_error_i;
  assign p1_error_o     = p1_ack_o & outport_error_i;
  assign p0_read_data_o = outport_read_data_i;
  assign p1_read_data_o = outport_read_data_i;

endmodule
